des_cbc_feeder: RTL

//  Upstream stage for the DES encrypt core: packs an 8-bit byte stream into 64-bit plaintext blocks.

---
 rtl/des_cbc_feeder_if.sv | 26 ++
 rtl/des_cbc_feeder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/des_cbc_feeder_if.sv
// Byte-stream, block and ciphertext-return signals between the DES CBC feeder and its neighbours.
// The slave modport is the feeder's view; master is the surrounding environment.
interface des_cbc_feeder_if;
   logic [63:0] iv;
   logic        iv_load;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [63:0] blk_out;
   logic        blk_valid;
   logic        blk_last;
   logic        blk_ready;
   logic [63:0] ct_in;
   logic        ct_valid;

   modport slave (
      input  iv, iv_load, s_data, s_valid, s_last, blk_ready, ct_in, ct_valid,
      output s_ready, blk_out, blk_valid, blk_last
   );

   modport master (
      output iv, iv_load, s_data, s_valid, s_last, blk_ready, ct_in, ct_valid,
      input  s_ready, blk_out, blk_valid, blk_last
   );
endinterface

// File: rtl/des_cbc_feeder.sv
// Packs a byte stream into 64-bit DES plaintext blocks with PKCS#5 padding or zero fill,
// XORs each block with the CBC chaining value and hands it to the encrypt core.
module des_cbc_feeder #(
   parameter bit PAD_EN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   des_cbc_feeder_if.slave bus
);

   typedef enum logic [1:0] {FILL, HOLD, WAIT_CT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] buf_q, buf_d;
   logic [63:0] iv_q, iv_d;
   logic [63:0] chain_q, chain_d;
   logic [63:0] blk_out_q, blk_out_d;
   logic        blk_last_q, blk_last_d;
   logic        pend_pad_q, pend_pad_d;
   logic        msg_q, msg_d;

   logic        accept;
   logic        idle;
   logic [7:0]  pad_byte;

   assign accept = (state_q == FILL) && bus.s_valid;
   // msg_q separates "between messages" from "between blocks of one message" when cnt is 0
   assign idle   = (state_q == FILL) && (cnt_q == 3'd0) && !msg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         cnt_q      <= 3'd0;
         buf_q      <= 64'h0;
         iv_q       <= 64'h0;
         chain_q    <= 64'h0;
         blk_out_q  <= 64'h0;
         blk_last_q <= 1'b0;
         pend_pad_q <= 1'b0;
         msg_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         iv_q       <= iv_d;
         chain_q    <= chain_d;
         blk_out_q  <= blk_out_d;
         blk_last_q <= blk_last_d;
         pend_pad_q <= pend_pad_d;
         msg_q      <= msg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (accept && ((cnt_q == 3'd7) || bus.s_last)) state_d = HOLD;
         HOLD:    if (bus.blk_ready) state_d = WAIT_CT;
         WAIT_CT: if (bus.ct_valid) state_d = pend_pad_q ? HOLD : FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      iv_d       = iv_q;
      chain_d    = chain_q;
      blk_out_d  = blk_out_q;
      blk_last_d = blk_last_q;
      pend_pad_d = pend_pad_q;
      msg_d      = msg_q;
      pad_byte   = PAD_EN ? 8'(7 - int'(cnt_q)) : 8'h00;

      if (bus.iv_load && idle) begin
         iv_d    = bus.iv;
         chain_d = bus.iv;
      end

      if (accept) begin
         buf_d[63 - 8*int'(cnt_q) -: 8] = bus.s_data;
         cnt_d = cnt_q + 3'd1;
         msg_d = !bus.s_last;
         if (cnt_q == 3'd7) begin
            blk_last_d = bus.s_last && !PAD_EN;
            pend_pad_d = bus.s_last && PAD_EN;
            blk_out_d  = buf_d ^ chain_d;
         end else if (bus.s_last) begin
            for (int j = 0; j < 8; j++) begin
               if (j > int'(cnt_q)) buf_d[63 - 8*j -: 8] = pad_byte;
            end
            blk_last_d = 1'b1;
            pend_pad_d = 1'b0;
            blk_out_d  = buf_d ^ chain_d;
         end
      end

      if ((state_q == WAIT_CT) && bus.ct_valid) begin
         cnt_d   = 3'd0;
         chain_d = bus.ct_in;
         if (pend_pad_q) begin
            // Full final block under PKCS#5 needs a whole block of 0x08 padding
            buf_d      = 64'h0808080808080808;
            blk_last_d = 1'b1;
            pend_pad_d = 1'b0;
            blk_out_d  = 64'h0808080808080808 ^ bus.ct_in;
         end else if (blk_last_q) begin
            chain_d = iv_q;
         end
      end
   end

   always_comb begin
      bus.s_ready   = (state_q == FILL);
      bus.blk_valid = (state_q == HOLD);
      bus.blk_out   = blk_out_q;
      bus.blk_last  = blk_last_q;
   end

endmodule
